// File: rtl/qcv_mem_arbiter_if.sv
// qcv_mem_arbiter_if: fetch, LSU and unified-memory request/response signals.
//   master: arbiter view (takes fetch/LSU requests and memory responses, drives grants, responses and the memory request)
//   slave:  environment view (core requesters plus the memory)
interface qcv_mem_arbiter_if;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;
   modport master (
      input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
             data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
             mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );
   modport slave (
      output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
             data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
             mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/qcv_mem_arbiter.sv
// qcv_mem_arbiter: 2:1 fetch/LSU arbiter onto one req/gnt/rvalid memory port with in-order response routing.
//   clk_i, rst_i (async, active-high); bus: qcv_mem_arbiter_if.master;
//   busy_o: transactions outstanding; unexp_rsp_o: sticky, response arrived with nothing outstanding.
module qcv_mem_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   qcv_mem_arbiter_if.master    bus,
   output logic                 busy_o,
   output logic                 unexp_rsp_o
);
   localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 2);
   typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;
   state_t                     state;
   logic [SW-1:0]              starve_cnt;
   logic [CW-1:0]              count;
   logic [PW-1:0]              wptr, rptr;
   logic [MAX_OUTSTANDING-1:0] tags;
   logic starve_win, sel_d, req_sel, full, push, pop;
   always_comb begin
      starve_win         = (STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT)) && bus.instr_req_i;
      // A locked source keeps the port until granted, whatever the other side does
      sel_d              = (state == LOCK_D) || (state == IDLE && bus.data_req_i && !starve_win);
      req_sel            = sel_d ? bus.data_req_i : bus.instr_req_i;
      full               = count == CW'(MAX_OUTSTANDING);
      bus.mem_req_o      = req_sel && !full && !rst_i;
      bus.mem_we_o       = sel_d && bus.data_we_i;
      bus.mem_be_o       = sel_d ? bus.data_be_i : 4'hF;
      bus.mem_addr_o     = sel_d ? bus.data_addr_i : bus.instr_addr_i;
      bus.mem_wdata_o    = sel_d ? bus.data_wdata_i : 32'h0;
      push               = bus.mem_req_o && bus.mem_gnt_i;
      bus.data_gnt_o     = push && sel_d;
      bus.instr_gnt_o    = push && !sel_d;
      // count is held at 0 during reset, so responses are swallowed there too
      pop                = bus.mem_rvalid_i && count != '0;
      bus.data_rvalid_o  = pop && tags[rptr];
      bus.instr_rvalid_o = pop && !tags[rptr];
      bus.instr_rdata_o  = bus.mem_rdata_i;
      bus.data_rdata_o   = bus.mem_rdata_i;
      bus.instr_err_o    = bus.mem_err_i;
      bus.data_err_o     = bus.mem_err_i;
      busy_o             = count != '0;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         count       <= '0;
         wptr        <= '0;
         rptr        <= '0;
         unexp_rsp_o <= 1'b0;
      end else begin
         state <= state == IDLE ? (bus.mem_req_o && !bus.mem_gnt_i ? (sel_d ? LOCK_D : LOCK_I) : IDLE)
                                : (!req_sel || bus.mem_gnt_i ? IDLE : state);
         if (!bus.instr_req_i || bus.instr_gnt_o) starve_cnt <= '0;
         else if (bus.data_gnt_o && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (push) wptr <= wptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wptr + 1'b1;
         if (pop) rptr <= rptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rptr + 1'b1;
         if (bus.mem_rvalid_i && count == '0) unexp_rsp_o <= 1'b1;
      end
   end
   // Tag storage: 1 = data, 0 = fetch
   always_ff @(posedge clk_i) begin
      if (push) tags[wptr] <= sel_d;
   end
endmodule
